// File: rtl/add_approx_pkg.sv
// Shared widths, result type and legal approximation range for the approximate add/sub family.
package add_approx_pkg;
  localparam int OP_W        = 8;
  localparam int RES_W       = 9;
  localparam int STAGE_SPLIT = 4;
  localparam int APPROX_MAX  = 4;

  typedef logic [RES_W-1:0] res_t;
endpackage

// File: rtl/sub8u_approx_pipe_if.sv
// Operand/result handshake bundle for sub8u_approx_pipe; master drives operands and result ready.
interface sub8u_approx_pipe_if;
  import add_approx_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_a;
  logic [OP_W-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  res_t            out_d;
  logic            out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_d, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_d, out_err
  );
endinterface

// File: rtl/sub4_approx_slice.sv
// Combinational 4-bit subtract slice: the low APPROX bits are A^B with no borrow chain, the rest ripple.
// Zero latency; no handshake.
module sub4_approx_slice
  import add_approx_pkg::*;
#(
  parameter int APPROX = 0
) (
  input  logic [STAGE_SPLIT-1:0] a,
  input  logic [STAGE_SPLIT-1:0] b,
  input  logic                   bin,
  output logic [STAGE_SPLIT-1:0] d,
  output logic                   bout
);
  always_comb begin : ripple
    logic bw;
    bw = bin;
    d  = '0;
    for (int i = 0; i < STAGE_SPLIT; i++) begin
      if (i < APPROX) begin
        d[i] = a[i] ^ b[i];
        // the borrow entering the first exact bit is defined as zero
        bw   = 1'b0;
      end else begin
        d[i] = a[i] ^ b[i] ^ bw;
        bw   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
      end
    end
    bout = bw;
  end
endmodule

// File: rtl/sub8u_approx_pipe.sv
// Two-stage approximate 8-bit subtractor with exact-result error flag; 2 register stages, 1 result/cycle.
// Backpressure: in_ready is combinational from out_ready through the stage-advance chain, no skid buffer.
module sub8u_approx_pipe
  import add_approx_pkg::*;
#(
  parameter int APPROX_BITS = 2,
  parameter int WIDTH       = OP_W
) (
  input logic                clk,
  input logic                rst_n,
  sub8u_approx_pipe_if.slave io
);
  localparam int HI_W = OP_W - STAGE_SPLIT;

  if (APPROX_BITS < 0 || APPROX_BITS > APPROX_MAX || WIDTH != OP_W || HI_W != STAGE_SPLIT) begin : g_bad_param
    $error("sub8u_approx_pipe: unsupported APPROX_BITS or WIDTH");
  end

  logic                   s1_valid;
  logic                   s2_valid;
  logic                   s1_adv;
  logic                   s2_adv;
  logic [STAGE_SPLIT-1:0] s1_d_lo;
  logic [STAGE_SPLIT-1:0] s1_x_lo;
  logic                   s1_bout;
  logic                   s1_bx;
  logic [HI_W-1:0]        s1_a_hi;
  logic [HI_W-1:0]        s1_b_hi;
  res_t                   s2_d;
  logic                   s2_err;

  logic [STAGE_SPLIT-1:0] lo_d;
  logic                   lo_bout;
  logic [STAGE_SPLIT:0]   lo_exact;
  logic [HI_W-1:0]        hi_d;
  logic                   hi_bout;
  logic [HI_W:0]          hi_exact;
  res_t                   approx_res;
  res_t                   exact_res;
  logic                   err_nxt;

  assign s2_adv      = !s2_valid || io.out_ready;
  assign s1_adv      = !s1_valid || s2_adv;
  assign io.in_ready = s1_adv;

  assign io.out_valid = s2_valid;
  assign io.out_d     = s2_d;
  assign io.out_err   = s2_err;

  sub4_approx_slice #(.APPROX(APPROX_BITS)) u_lo (
    .a    (io.in_a[STAGE_SPLIT-1:0]),
    .b    (io.in_b[STAGE_SPLIT-1:0]),
    .bin  (1'b0),
    .d    (lo_d),
    .bout (lo_bout)
  );

  assign lo_exact = {1'b0, io.in_a[STAGE_SPLIT-1:0]} - {1'b0, io.in_b[STAGE_SPLIT-1:0]};

  sub4_approx_slice #(.APPROX(0)) u_hi (
    .a    (s1_a_hi),
    .b    (s1_b_hi),
    .bin  (s1_bout),
    .d    (hi_d),
    .bout (hi_bout)
  );

  // MSB of the 5-bit difference is the exact borrow out of bit 7
  assign hi_exact   = {1'b0, s1_a_hi} - {1'b0, s1_b_hi} - {{HI_W{1'b0}}, s1_bx};
  assign approx_res = {hi_bout, hi_d, s1_d_lo};
  assign exact_res  = {hi_exact, s1_x_lo};
  assign err_nxt    = (APPROX_BITS != 0) && (approx_res != exact_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_d_lo  <= '0;
      s1_x_lo  <= '0;
      s1_bout  <= 1'b0;
      s1_bx    <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
    end else if (s1_adv) begin
      s1_valid <= io.in_valid;
      if (io.in_valid) begin
        s1_d_lo <= lo_d;
        s1_bout <= lo_bout;
        s1_x_lo <= lo_exact[STAGE_SPLIT-1:0];
        s1_bx   <= lo_exact[STAGE_SPLIT];
        s1_a_hi <= io.in_a[OP_W-1:STAGE_SPLIT];
        s1_b_hi <= io.in_b[OP_W-1:STAGE_SPLIT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_d     <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_d   <= approx_res;
        s2_err <= err_nxt;
      end
    end
  end
endmodule

// File: tb/tb_sub8u_approx_pipe.sv
// Randomized and directed bench for sub8u_approx_pipe (APPROX_BITS=2 and 0 instances) against an arithmetic model.
module tb_sub8u_approx_pipe;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  sub8u_approx_pipe_if ifa ();
  sub8u_approx_pipe_if ifz ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_a      = in_a;
  assign ifa.in_b      = in_b;
  assign ifa.out_ready = out_ready;
  assign ifz.in_valid  = in_valid;
  assign ifz.in_a      = in_a;
  assign ifz.in_b      = in_b;
  assign ifz.out_ready = out_ready;

  sub8u_approx_pipe #(.APPROX_BITS(2), .WIDTH(8)) dut_a (.clk(clk), .rst_n(rst_n), .io(ifa));
  sub8u_approx_pipe #(.APPROX_BITS(0), .WIDTH(8)) dut_z (.clk(clk), .rst_n(rst_n), .io(ifz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // k low bits are plain XOR; the upper slices subtract exactly with the borrow wrapping into bit 8
  function automatic int model(input int a, input int b, input int k);
    int h;
    h = (a >> k) - (b >> k);
    return ((h & ((1 << (9 - k)) - 1)) << k) | ((a ^ b) & ((1 << k) - 1));
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.out_valid) begin
        if (qa.size() == 0) begin
          chk("spurious_result", 1, 0);
        end else begin
          chk("d_ap2", int'(ifa.out_d), model(int'(qa[0]), int'(qb[0]), 2));
          chk("err_ap2", int'(ifa.out_err),
              int'(model(int'(qa[0]), int'(qb[0]), 2) != model(int'(qa[0]), int'(qb[0]), 0)));
          chk("vld_ap0", int'(ifz.out_valid), 1);
          chk("d_ap0", int'(ifz.out_d), model(int'(qa[0]), int'(qb[0]), 0));
          chk("err_ap0", int'(ifz.out_err), 0);
          if (out_ready) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && ifa.in_ready) begin
        qa.push_back(in_a);
        qb.push_back(in_b);
      end
    end
  end

  // presents one pair and returns just after the edge that accepts it
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ifa.in_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic one(input logic [7:0] a, input logic [7:0] b, input int exp_d, input int exp_e);
    out_ready = 1'b1;
    chk("dir_in_rdy", int'(ifa.in_ready), 1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_stage1_vld", int'(ifa.out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_stage2_vld", int'(ifa.out_valid), 1);
    chk("dir_d", int'(ifa.out_d), exp_d);
    chk("dir_err", int'(ifa.out_err), exp_e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", int'(ifa.out_valid), 0);
    chk("rst_out_d", int'(ifa.out_d), 0);
    chk("rst_out_err", int'(ifa.out_err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(ifa.in_ready), 1);

    one(8'd10, 8'd3, 'h009, 1);
    one(8'd3, 8'd10, 'h1F9, 0);
    one(8'd0, 8'd1, 'h001, 1);
    one(8'd200, 8'd200, 'h000, 0);
    one(8'd17, 8'd200, 'h149, 0);

    base = n_out;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) send(8'(i * 37 + 5), 8'(i * 11 + 90));
      end
      begin
        n = 0;
        while (!ifa.out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        chk("full_in_ready", int'(ifa.in_ready), 0);
        chk("stall_out_valid", int'(ifa.out_valid), 1);
        out_ready = 1'b1;
      end
    join
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("stream_count", n_out - base, 4);

    send(8'd50, 8'd60);
    send(8'd70, 8'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(ifa.out_valid), 0);
    chk("arst_out_d", int'(ifa.out_d), 0);
    chk("arst_in_ready", int'(ifa.in_ready), 1);
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", int'(ifa.out_valid), 0);
    end
    chk("post_rst_in_ready", int'(ifa.in_ready), 1);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end

    base = n_out;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) send(8'(a), 8'(b));
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("sweep_count", n_out - base, 65536);
    chk("queue_drained", qa.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sub8u_approx_pipe.md
Name: sub8u_approx_pipe

Overview:
- Two-stage pipelined 8-bit unsigned approximate subtractor with valid/ready handshakes on both sides.
- It is the inverse-direction companion of the team's approximate 8-bit adders. It computes D = A - B with a 9-bit result: bit 8 is borrow-out.
- The low APPROX_BITS bits are produced without a borrow chain, which cuts LUT count and delay in FPGA-targeted datapaths.
- A per-result error flag reports when the approximate result differs from the exact one. This supports online MAE/EP characterisation.

Parameters:
- APPROX_BITS, 2, number of LSBs computed approximately (legal range 0..4); 0 gives an exact subtractor.
- WIDTH, 8, operand width; fixed at 8 for this revision, with the stage split at bit 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  8  minuend A.
- in_b  in  8  subtrahend B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_d  out  9  result: [7:0] difference mod 256, [8] borrow-out.
- out_err  out  1  1 when out_d differs from the exact {borrow, A-B}.

Behaviour:
- Reset: asynchronous assert on rst_n low.
  - All valid flags clear, so out_valid=0. out_d=0, out_err=0. in_ready=1 immediately after release.
  - Reset mid-operation discards both in-flight stages; no partial result is emitted.
- Approximate arithmetic:
  - For i < APPROX_BITS: D[i] = A[i] XOR B[i].
  - The borrow into bit APPROX_BITS is forced to 0.
  - Bits APPROX_BITS..7 are an exact ripple subtract of the upper operand slices. D[8] is the borrow out of bit 7.
- Exact reference: {bx, X} = {1'b0,A} - {1'b0,B}, computed in parallel and carried alongside the result.
  - out_err = ({bx, X} != approx result).
- Stage 1, on accept:
  - Registers D[3:0], the borrow out of bit 3, A[7:4] and B[7:4].
  - Registers the exact low nibble and the exact borrow out of bit 3.
- Stage 2: computes D[7:4] and D[8] from the stage-1 borrow; computes the exact high part and out_err; registers everything into the output stage.
- Latency: 2 cycles from the in_valid&in_ready edge to out_valid, with no stall. Throughput is 1 result per cycle.
- Handshake:
  - Transfer occurs on valid&ready at a rising edge.
  - out_valid, out_d and out_err hold stable while out_valid=1 and out_ready=0.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready (one ready path, no skid).
  - in_valid may drop without a transfer. The block never drops a result or duplicates one.
- Full pipeline:
  - With both stages valid and out_ready=0: in_ready=0.
  - With out_ready=1 in the same cycle: all stages shift and a new operand pair is accepted (simultaneous accept/emit).
- Boundaries:
  - A=B gives 0, err=0.
  - A<B wraps mod 256 with D[8]=1.
  - APPROX_BITS=0 forces out_err constant 0.

Decomposition:
- Shared package add_approx_pkg holds:
  - OP_W=8 and RES_W=9.
  - STAGE_SPLIT=4.
  - A typedef for the 9-bit result.
  - The legal APPROX_BITS maximum (4), asserted at elaboration.
- One sub-module, sub4_approx_slice, is natural: a combinational 4-bit slice with operands, borrow-in and an approximate-bit count, producing difference and borrow-out. It is instantiated for the low slice (with APPROX_BITS) and the high slice (approx count 0).

Test Plan:
- Reset then A=10, B=3, out_ready=1, APPROX_BITS=2 -> 2 cycles later out_d=0x009, out_err=1 (exact 7).
- A=3, B=10 -> out_d=0x1F9, out_err=0 (matches exact -7 with borrow).
- A=0, B=1 -> out_d=0x001, out_err=1 (exact 0x1FF); A=200, B=200 -> out_d=0x000, out_err=0.
- Stream 4 back-to-back pairs, hold out_ready=0 for 3 cycles after the first result -> in_ready=0 once both stages are full; results arrive in order, with values stable during the stall; no loss or duplication.
- Pulse rst_n low while 2 results are in flight -> out_valid=0 asynchronously; after release no stale results appear and in_ready=1.
- APPROX_BITS=0 sweep over all 65536 pairs -> out_d equals the exact {borrow, A-B} and out_err=0 throughout.
